// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use and MDU-busy
// stalls, exception/eret redirection, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_rs_used,
  input  logic        d_rt_used,
  input  logic        d_mdu_use,
  input  logic        e_is_load,
  input  logic [4:0]  e_wr_reg,
  input  logic        e_mdu_start,
  input  logic        e_mdu_div,
  input  logic        m_exc_req,
  input  logic        m_eret,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        flush_de,
  output logic        flush_fd,
  output logic        flush_em,
  output logic [1:0]  pc_redirect,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  mdu_state_e  state;
  logic [3:0]  mdu_cnt;
  logic [31:0] stall_cnt_q;
  logic        lu, mh, st, ex;

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = e_is_load && (e_wr_reg != 5'd0) &&
              ((d_rs_used && (d_rs == e_wr_reg)) ||
               (d_rt_used && (d_rt == e_wr_reg)));
  assign mh = d_mdu_use && (state == BUSY);
  assign st = lu || mh;
  assign ex = m_exc_req || m_eret;

  // Gating with clr_n keeps every output quiet during reset even while the
  // decode inputs still show a hazard.
  always_comb begin
    stall_pc    = 1'b0;
    stall_fd    = 1'b0;
    flush_de    = 1'b0;
    flush_fd    = 1'b0;
    flush_em    = 1'b0;
    pc_redirect = 2'b00;
    if (clr_n) begin
      if (ex) begin
        flush_fd    = 1'b1;
        flush_de    = 1'b1;
        flush_em    = 1'b1;
        pc_redirect = m_exc_req ? 2'b01 : 2'b10;
      end else if (st) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        flush_de = 1'b1;
      end
    end
  end

  assign mdu_busy  = clr_n && (state == BUSY);
  assign stall_cnt = stall_cnt_q;

  // A started mult/div runs to completion; only reset can abort it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      mdu_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (e_mdu_start && !ex) begin
            mdu_cnt <= e_mdu_div ? DIV_LD : MULT_LD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          mdu_cnt <= mdu_cnt - 4'd1;
          if (mdu_cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mdu_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) stall_cnt_q <= 32'd0;
    else if (stall_fd && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed expectations per scenario.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [4:0]  d_rs, d_rt, e_wr_reg;
  logic        d_rs_used, d_rt_used, d_mdu_use, e_is_load;
  logic        e_mdu_start, e_mdu_div, m_exc_req, m_eret;
  logic        stall_pc, stall_fd, flush_de, flush_fd, flush_em, mdu_busy;
  logic [1:0]  pc_redirect;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .clr_n(clr_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_mdu_use(d_mdu_use), .e_is_load(e_is_load), .e_wr_reg(e_wr_reg),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
    .m_exc_req(m_exc_req), .m_eret(m_eret),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .flush_de(flush_de),
    .flush_fd(flush_fd), .flush_em(flush_em), .pc_redirect(pc_redirect),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_rs_used = 1'b0; d_rt_used = 1'b0;
    d_mdu_use = 1'b0; e_is_load = 1'b0; e_wr_reg = 5'd0;
    e_mdu_start = 1'b0; e_mdu_div = 1'b0; m_exc_req = 1'b0; m_eret = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr_n = 1'b0;
    e_is_load = 1'b1; e_wr_reg = 5'd3; d_rs = 5'd3; d_rs_used = 1'b1; m_exc_req = 1'b1;
    #12;
    n_cmp++;
    if ({stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect, mdu_busy} !== 8'h00) begin
      n_bad++; $display("FAIL reset_outputs got=%b want=00000000",
        {stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect, mdu_busy});
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt got=%h want=0", stall_cnt); end
    @(negedge clk);
    idle_inputs();
    clr_n = 1'b1;
    exp_cnt = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    e_is_load = 1'b1; e_wr_reg = 5'd3; d_rs = 5'd3; d_rs_used = 1'b1;
    #1;
    n_cmp++;
    if ({stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect} !== 7'b1110000) begin
      n_bad++; $display("FAIL lu_stall got=%b want=1110000",
        {stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect});
    end
    exp_cnt++;
    @(negedge clk);
    e_is_load = 1'b0;  // load has advanced to M
    #1;
    n_cmp++;
    if ({stall_pc, stall_fd, flush_de} !== 3'b000) begin
      n_bad++; $display("FAIL lu_release got=%b want=000", {stall_pc, stall_fd, flush_de});
    end
    n_cmp++;
    if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_stall_cnt got=%0d want=1", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    @(negedge clk);
    e_is_load = 1'b1; e_wr_reg = 5'd0; d_rs = 5'd0; d_rs_used = 1'b1;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL lu_reg0 got=%b want=0", stall_fd); end
    e_wr_reg = 5'd3; d_rs = 5'd3; d_rs_used = 1'b0;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL lu_rs_unused got=%b want=0", stall_fd); end
    d_rt = 5'd3; d_rt_used = 1'b1;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b1) begin n_bad++; $display("FAIL lu_rt got=%b want=1", stall_fd); end
    d_rt = 5'd4;
    #1;
    n_cmp++;
    if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL lu_rt_other got=%b want=0", stall_fd); end
    idle_inputs();
  endtask

  task automatic test_mdu(input logic is_div, input int cycles);
    int busy_seen;
    @(negedge clk);
    e_mdu_start = 1'b1; e_mdu_div = is_div;
    #1;
    n_cmp++;
    if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL mdu_pre_start got=%b want=0", mdu_busy); end
    @(negedge clk);
    e_mdu_start = 1'b0; d_mdu_use = 1'b1;  // mflo right behind
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!mdu_busy) break;
      if (stall_fd) exp_cnt++;
      busy_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen !== cycles) begin
      n_bad++; $display("FAIL mdu_busy_len div=%b got=%0d want=%0d", is_div, busy_seen, cycles);
    end
    n_cmp++;
    if (stall_fd !== 1'b0) begin n_bad++; $display("FAIL mdu_release got=%b want=0", stall_fd); end
    n_cmp++;
    if (stall_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL mdu_stall_cnt div=%b got=%0d want=%0d", is_div, stall_cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_exception();
    @(negedge clk);
    e_is_load = 1'b1; e_wr_reg = 5'd7; d_rs = 5'd7; d_rs_used = 1'b1; m_exc_req = 1'b1;
    #1;
    n_cmp++;
    if ({stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect} !== 7'b0011101) begin
      n_bad++; $display("FAIL exc_over_lu got=%b want=0011101",
        {stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect});
    end
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL exc_stall_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
    idle_inputs();
    m_eret = 1'b1;
    #1;
    n_cmp++;
    if (pc_redirect !== 2'b10) begin n_bad++; $display("FAIL eret_redirect got=%b want=10", pc_redirect); end
    m_exc_req = 1'b1;
    #1;
    n_cmp++;
    if (pc_redirect !== 2'b01) begin n_bad++; $display("FAIL exc_beats_eret got=%b want=01", pc_redirect); end
    m_eret = 1'b0;
    e_mdu_start = 1'b1; e_mdu_div = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL exc_kills_start got=%b want=0", mdu_busy); end
  endtask

  task automatic test_mdu_not_cancelled();
    @(negedge clk);
    e_mdu_start = 1'b1;
    @(negedge clk);
    idle_inputs();
    m_exc_req = 1'b1;
    @(negedge clk);
    m_exc_req = 1'b0;
    #1;
    n_cmp++;
    if (mdu_busy !== 1'b1) begin n_bad++; $display("FAIL mdu_survives_exc got=%b want=1", mdu_busy); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL mdu_survives_done got=%b want=0", mdu_busy); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    e_mdu_start = 1'b1; e_mdu_div = 1'b1;
    @(negedge clk);          // count now 10
    idle_inputs();
    repeat (6) @(negedge clk);  // count now 4
    d_mdu_use = 1'b1; m_exc_req = 1'b0;
    #1;
    n_cmp++;
    if ({mdu_busy, stall_fd} !== 2'b11) begin
      n_bad++; $display("FAIL div_before_reset got=%b want=11", {mdu_busy, stall_fd});
    end
    m_exc_req = 1'b0;
    clr_n = 1'b0;
    #1;
    n_cmp++;
    if ({stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect, mdu_busy} !== 8'h00) begin
      n_bad++; $display("FAIL async_reset_outputs got=%b want=00000000",
        {stall_pc, stall_fd, flush_de, flush_fd, flush_em, pc_redirect, mdu_busy});
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL async_reset_cnt got=%h want=0", stall_cnt); end
    @(negedge clk);
    idle_inputs();
    clr_n = 1'b1;
    exp_cnt = 32'd0;
    @(negedge clk);
    n_cmp++;
    if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got=%b want=0", mdu_busy); end
  endtask

  task automatic test_saturation();
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF;
    want[2] = 32'hFFFF_FFFF; want[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    e_is_load = 1'b1; e_wr_reg = 5'd9; d_rt = 5'd9; d_rt_used = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (stall_cnt !== want[i]) begin
        n_bad++; $display("FAIL stall_cnt_sat step=%0d got=%h want=%h", i, stall_cnt, want[i]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu(1'b0, 5);
    test_mdu(1'b1, 10);
    test_exception();
    test_mdu_not_cancelled();
    test_reset_mid_div();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
